// File: rtl/sounder_pkg.sv
// Shared types and widths for the sounder receive framer.
package sounder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Sideband carried with each beat: {timestamp, tlast, teob, thas_time}
    localparam int SB_W  = 64 + 3;
    localparam int CNT_W = 32;
    localparam int ANT_W = 8;
    localparam int SPP_W = 16;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer with a registered upstream ready.
module axis_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          push;
    logic          pop;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (!push && pop) begin
            count_nxt = count - 2'd1;
        end
    end

    // Ready looks ahead at the post-update occupancy so a full buffer is never overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_nxt;
            s_ready <= en && (count_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/sounder_rx_framer.sv
// Frames the averaged sounder stream into packets bounded by spp and snapshot length ml,
// tagging burst timestamps, first-packet time and end-of-burst.
//   state   | meaning
//   S_IDLE  | waiting for cfg_en, config latched on entry to run
//   S_RUN   | accepting beats, counters advance on input handshake
//   S_DRAIN | burst finished with cfg_en low, emptying skid buffer
module sounder_rx_framer
    import sounder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIPC  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NIPC*WIDTH-1:0] i_axis_tdata,
    input  logic                  i_axis_tvalid,
    output logic                  i_axis_tready,
    output logic [NIPC*WIDTH-1:0] o_axis_tdata,
    output logic [NIPC-1:0]       o_axis_tkeep,
    output logic                  o_axis_tlast,
    output logic                  o_axis_tvalid,
    input  logic                  o_axis_tready,
    output logic [63:0]           o_axis_ttimestamp,
    output logic                  o_axis_thas_time,
    output logic                  o_axis_teob,
    input  logic                  cfg_en,
    input  logic [CNT_W-1:0]      ml,
    input  logic [ANT_W-1:0]      nant,
    input  logic [SPP_W-1:0]      spp,
    input  logic [63:0]           ts_init,
    input  logic [63:0]           ts_step
);

    localparam int DATA_W = NIPC * WIDTH;
    localparam int DW     = DATA_W + SB_W;

    logic [1:0]       rst_sync;
    logic             rst_s_n;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ml_r;
    logic [CNT_W-1:0] wcnt;
    logic [ANT_W-1:0] nant_r;
    logic [ANT_W-1:0] acnt;
    logic [SPP_W-1:0] spp_r;
    logic [SPP_W-1:0] pcnt;
    logic [63:0]      ts_reg;
    logic             first_pkt;
    logic             hs;
    logic             snap_end;
    logic             beat_last;
    logic             burst_end;
    logic [SB_W-1:0]  sb_in;
    logic [DW-1:0]    skid_m_data;
    logic             skid_m_valid;

    // Assert asynchronously, release synchronously to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_s_n = rst_sync[1];

    assign hs        = i_axis_tvalid & i_axis_tready;
    assign snap_end  = (wcnt == ml_r);
    assign beat_last = snap_end | (pcnt == spp_r);
    assign burst_end = hs & snap_end & (acnt == nant_r);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_en) state_nxt = S_RUN;
            S_RUN:   if (burst_end && !cfg_en) state_nxt = S_DRAIN;
            S_DRAIN: if (!skid_m_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_s_n) begin
        if (!rst_s_n) begin
            ml_r      <= CNT_W'(1);
            nant_r    <= ANT_W'(1);
            spp_r     <= SPP_W'(1);
            wcnt      <= CNT_W'(1);
            acnt      <= ANT_W'(1);
            pcnt      <= SPP_W'(1);
            ts_reg    <= '0;
            first_pkt <= 1'b1;
        end else if (state == S_IDLE) begin
            if (cfg_en) begin
                ml_r      <= (ml   == '0) ? CNT_W'(1) : ml;
                nant_r    <= (nant == '0) ? ANT_W'(1) : nant;
                spp_r     <= (spp  == '0) ? SPP_W'(1) : spp;
                ts_reg    <= ts_init;
                wcnt      <= CNT_W'(1);
                acnt      <= ANT_W'(1);
                pcnt      <= SPP_W'(1);
                first_pkt <= 1'b1;
            end
        end else if (hs) begin
            pcnt <= beat_last ? SPP_W'(1) : pcnt + SPP_W'(1);
            if (snap_end) begin
                wcnt      <= CNT_W'(1);
                acnt      <= (acnt == nant_r) ? ANT_W'(1) : acnt + ANT_W'(1);
                first_pkt <= 1'b1;
            end else begin
                wcnt <= wcnt + CNT_W'(1);
                if (beat_last) first_pkt <= 1'b0;
            end
            if (burst_end) begin
                ts_reg <= ts_reg + ts_step;
            end
        end
    end

    assign sb_in = {ts_reg, beat_last, (acnt == nant_r), (acnt == ANT_W'(1)) & first_pkt};

    axis_skid_buf #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_s_n),
        .en      (state_nxt == S_RUN),
        .s_data  ({sb_in, i_axis_tdata}),
        .s_valid (i_axis_tvalid),
        .s_ready (i_axis_tready),
        .m_data  (skid_m_data),
        .m_valid (skid_m_valid),
        .m_ready (o_axis_tready)
    );

    assign {o_axis_ttimestamp, o_axis_tlast, o_axis_teob, o_axis_thas_time, o_axis_tdata} = skid_m_data;
    assign o_axis_tvalid = skid_m_valid;
    assign o_axis_tkeep  = {NIPC{skid_m_valid}};

endmodule
